// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit and the
// ALU controller that consumes its ALUOp: opcodes, ALUOp codes, FSM state
// encodings, datapath select codes and the control-word layout.
// Optional build macro: MC_CTRL_BNE_EN (adds bne decoding).
package mc_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;
  localparam int ST_W    = 4;

  typedef logic [OP_W-1:0]    opcode_t;
  typedef logic [ALUOP_W-1:0] aluop_t;

  // Opcode field values (instr[31:26])
  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_BNE   = 6'b000101;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_SLTIU = 6'b001011;
  localparam opcode_t OP_LUI   = 6'b001111;
  localparam opcode_t OP_ORI   = 6'b001101;
  localparam opcode_t OP_ANDI  = 6'b001100;

  // ALUOp codes shared with the ALU controller
  localparam aluop_t ALUOP_MEM   = 3'b000;
  localparam aluop_t ALUOP_BEQ   = 3'b001;
  localparam aluop_t ALUOP_RTYPE = 3'b010;
  localparam aluop_t ALUOP_ADDI  = 3'b011;
  localparam aluop_t ALUOP_SLTIU = 3'b100;
  localparam aluop_t ALUOP_LUI   = 3'b101;
  localparam aluop_t ALUOP_ORI   = 3'b110;
  localparam aluop_t ALUOP_ANDI  = 3'b111;

  // FSM states; encodings 11..15 are never entered
  typedef enum logic [ST_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_IMMEX  = 4'd9,
    ST_IMMWB  = 4'd10
  } state_t;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // Instruction class used by the DECODE dispatch
  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_BRANCH,
    CLS_IMM,
    CLS_ILLEGAL
  } op_class_t;

  // Control word produced by the output decoder
  typedef struct packed {
    aluop_t     alu_op;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_word_t;

  // Classify an opcode for the DECODE dispatch
  function automatic op_class_t op_class(input opcode_t op);
    op_class_t cls;
    case (op)
      OP_LW, OP_SW:                                  cls = CLS_MEM;
      OP_RTYPE:                                      cls = CLS_RTYPE;
      OP_BEQ:                                        cls = CLS_BRANCH;
`ifdef MC_CTRL_BNE_EN
      OP_BNE:                                        cls = CLS_BRANCH;
`endif
      OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI, OP_ANDI:    cls = CLS_IMM;
      default:                                       cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // ALUOp for the immediate-execute state, selected by the latched opcode
  function automatic aluop_t imm_aluop(input opcode_t op);
    aluop_t code;
    case (op)
      OP_ADDI:  code = ALUOP_ADDI;
      OP_SLTIU: code = ALUOP_SLTIU;
      OP_LUI:   code = ALUOP_LUI;
      OP_ORI:   code = ALUOP_ORI;
      OP_ANDI:  code = ALUOP_ANDI;
      default:  code = ALUOP_MEM;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of the current FSM state (plus latched opcode and
// the two qualifying inputs) into the datapath control word. Everything is
// Moore except the FETCH IR/PC enables, which follow mem_ready, and the
// BRANCH PC enable, which follows the ALU zero flag.
// Optional build macro: MC_CTRL_BNE_EN (bne inverts the branch condition).
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  opcode_t    op_q,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output ctrl_word_t ctrl
);

  // Per-state control word; anything not set for a state stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_MEM;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_MEM;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_MEM;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_BEQ;
        ctrl.pc_src    = PCSRC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
        // bne shares the subtract compare; only the taken sense flips
        ctrl.pc_en     = (op_q == OP_BNE) ? ~alu_zero : alu_zero;
`else
        ctrl.pc_en     = alu_zero;
`endif
      end
      ST_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_aluop(op_q);
      end
      ST_IMMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control unit. Steps each instruction through
// fetch/decode/execute/memory/writeback, latches the opcode in DECODE for
// the later states, and drives the datapath control word. While rst_i is
// high every output is held at 0.
// Optional build macro: MC_CTRL_BNE_EN (decode bne into the branch path).
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               alu_zero_i,
  input  logic               mem_ready_i,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               pc_en_o,
  output logic [1:0]         pc_src_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic               illegal_o,
  output logic [3:0]         state_o
);

  state_t     state_reg;
  state_t     state_next;
  opcode_t    op_q_reg;
  logic       illegal_next;
  ctrl_word_t ctrl_raw;
  ctrl_word_t ctrl_out;

  // State register and opcode latch; the opcode is captured while decoding
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_FETCH;
      op_q_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) begin
        op_q_reg <= instr_op_i;
      end
    end
  end

  // Next-state selection and the illegal-opcode flag raised in DECODE
  always_comb begin
    state_next   = state_reg;
    illegal_next = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (mem_ready_i) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        // op_q is not yet loaded here, so dispatch on the live IR field
        case (op_class(instr_op_i))
          CLS_MEM:    state_next = ST_MEMADR;
          CLS_RTYPE:  state_next = ST_EXEC;
          CLS_BRANCH: state_next = ST_BRANCH;
          CLS_IMM:    state_next = ST_IMMEX;
          default: begin
            state_next   = ST_FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      ST_MEMADR: state_next = (op_q_reg == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (mem_ready_i) state_next = ST_MEMWB;
      end
      ST_MEMWB:  state_next = ST_FETCH;
      ST_MEMWR: begin
        if (mem_ready_i) state_next = ST_FETCH;
      end
      ST_EXEC:   state_next = ST_RWB;
      ST_RWB:    state_next = ST_FETCH;
      ST_BRANCH: state_next = ST_FETCH;
      ST_IMMEX:  state_next = ST_IMMWB;
      ST_IMMWB:  state_next = ST_FETCH;
      default:   state_next = ST_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_reg),
    .op_q      (op_q_reg),
    .mem_ready (mem_ready_i),
    .alu_zero  (alu_zero_i),
    .ctrl      (ctrl_raw)
  );

  // Hold every output low while reset is asserted so an aborted access
  // cannot leave a request or enable active
  always_comb begin
    ctrl_out = '0;
    if (!rst_i) begin
      ctrl_out = ctrl_raw;
    end
  end

  assign ALUOp_o      = ctrl_out.alu_op;
  assign pc_en_o      = ctrl_out.pc_en;
  assign pc_src_o     = ctrl_out.pc_src;
  assign iord_o       = ctrl_out.iord;
  assign mem_read_o   = ctrl_out.mem_read;
  assign mem_write_o  = ctrl_out.mem_write;
  assign ir_write_o   = ctrl_out.ir_write;
  assign reg_write_o  = ctrl_out.reg_write;
  assign reg_dst_o    = ctrl_out.reg_dst;
  assign mem_to_reg_o = ctrl_out.mem_to_reg;
  assign alu_src_a_o  = ctrl_out.alu_src_a;
  assign alu_src_b_o  = ctrl_out.alu_src_b;
  assign illegal_o    = illegal_next & ~rst_i;
  assign state_o      = rst_i ? 4'd0 : state_reg;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed testbench for mc_main_ctrl: reset, R-type, lw with memory waits,
// beq taken/not taken, the five immediates, illegal opcode, fetch stall and
// reset during a store. Honours MC_CTRL_BNE_EN for the bne case.
module tb_mc_main_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       ready;
  logic [2:0] alu_op;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       src_a;
  logic [1:0] src_b;
  logic       illegal;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  mc_main_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_op_i   (op),
    .alu_zero_i   (zero),
    .mem_ready_i  (ready),
    .ALUOp_o      (alu_op),
    .pc_en_o      (pc_en),
    .pc_src_o     (pc_src),
    .iord_o       (iord),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_write_o  (reg_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_a_o  (src_a),
    .alu_src_b_o  (src_b),
    .illegal_o    (illegal),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Move 2 ns past the next rising edge; inputs are changed there and
  // outputs are sampled 1 ns later, well away from either edge
  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] all_out();
    return {11'd0, alu_op, pc_en, pc_src, iord, mem_read, mem_write, ir_write,
            reg_write, reg_dst, mem_to_reg, src_a, src_b, illegal, state};
  endfunction

  logic [5:0] imm_ops  [5];
  logic [2:0] imm_codes[5];

  initial begin
    imm_ops[0] = 6'b001101; imm_codes[0] = 3'b110; // ori
    imm_ops[1] = 6'b001100; imm_codes[1] = 3'b111; // andi
    imm_ops[2] = 6'b001011; imm_codes[2] = 3'b100; // sltiu
    imm_ops[3] = 6'b001111; imm_codes[3] = 3'b101; // lui
    imm_ops[4] = 6'b001000; imm_codes[4] = 3'b011; // addi

    rst = 1'b1; op = 6'b000000; zero = 1'b0; ready = 1'b1;

    // Reset held for two edges: every output low
    adv(); #1 chk("rst_all_zero_1", all_out(), 32'd0);
    adv(); #1 chk("rst_all_zero_2", all_out(), 32'd0);

    // R-type: 0,1,6,7,0
    rst = 1'b0; #1;
    chk("r_fetch_state", state, 4'd0);
    chk("r_fetch_memrd", mem_read, 1'b1);
    chk("r_fetch_irw", ir_write, 1'b1);
    chk("r_fetch_pcen", pc_en, 1'b1);
    chk("r_fetch_srcb", src_b, 2'b01);
    adv(); #1;
    chk("r_decode_state", state, 4'd1);
    chk("r_decode_srcb", src_b, 2'b11);
    adv(); #1;
    chk("r_exec_state", state, 4'd6);
    chk("r_exec_aluop", alu_op, 3'b010);
    chk("r_exec_srca", src_a, 1'b1);
    adv(); #1;
    chk("r_rwb_state", state, 4'd7);
    chk("r_rwb_regw", reg_write, 1'b1);
    chk("r_rwb_regdst", reg_dst, 1'b1);
    adv(); #1;
    chk("r_back_fetch", state, 4'd0);

    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4,0
    op = 6'b100011;
    adv(); #1 chk("lw_decode_state", state, 4'd1);
    adv(); #1;
    chk("lw_memadr_state", state, 4'd2);
    chk("lw_memadr_srcb", src_b, 2'b10);
    ready = 1'b0;
    adv(); #1;
    chk("lw_memrd1_state", state, 4'd3);
    chk("lw_memrd1_iord", iord, 1'b1);
    chk("lw_memrd1_rd", mem_read, 1'b1);
    adv(); #1;
    chk("lw_memrd2_state", state, 4'd3);
    chk("lw_memrd2_iord", iord, 1'b1);
    chk("lw_memrd2_rd", mem_read, 1'b1);
    adv(); ready = 1'b1; #1;
    chk("lw_memrd3_state", state, 4'd3);
    chk("lw_memrd3_rd", mem_read, 1'b1);
    adv(); #1;
    chk("lw_memwb_state", state, 4'd4);
    chk("lw_memwb_m2r", mem_to_reg, 1'b1);
    chk("lw_memwb_regw", reg_write, 1'b1);
    adv(); #1 chk("lw_back_fetch", state, 4'd0);

    // beq taken
    op = 6'b000100; zero = 1'b1;
    adv(); #1 chk("beq1_decode_state", state, 4'd1);
    adv(); #1;
    chk("beq1_branch_state", state, 4'd8);
    chk("beq1_pcen", pc_en, 1'b1);
    chk("beq1_pcsrc", pc_src, 2'b01);
    chk("beq1_aluop", alu_op, 3'b001);
    adv(); #1 chk("beq1_back_fetch", state, 4'd0);

    // beq not taken
    zero = 1'b0;
    adv(); adv(); #1;
    chk("beq0_branch_state", state, 4'd8);
    chk("beq0_pcen", pc_en, 1'b0);
    adv(); #1 chk("beq0_back_fetch", state, 4'd0);

    // Immediates: IMMEX ALUOp, then IMMWB writes rt
    for (int i = 0; i < 5; i++) begin
      op = imm_ops[i];
      adv(); #1 chk("imm_decode_state", state, 4'd1);
      adv(); #1;
      chk("imm_immex_state", state, 4'd9);
      chk("imm_immex_aluop", alu_op, imm_codes[i]);
      chk("imm_immex_srcb", src_b, 2'b10);
      adv(); #1;
      chk("imm_immwb_state", state, 4'd10);
      chk("imm_immwb_regw", reg_write, 1'b1);
      chk("imm_immwb_regdst", reg_dst, 1'b0);
      adv(); #1 chk("imm_back_fetch", state, 4'd0);
    end

    // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH
    op = 6'b111111;
    chk("ill_fetch_noflag", illegal, 1'b0);
    adv(); #1;
    chk("ill_decode_state", state, 4'd1);
    chk("ill_decode_flag", illegal, 1'b1);
    chk("ill_decode_regw", reg_write, 1'b0);
    chk("ill_decode_memw", mem_write, 1'b0);
    adv(); #1;
    chk("ill_after_state", state, 4'd0);
    chk("ill_after_flag", illegal, 1'b0);

    // bne opcode: branch when enabled, illegal otherwise
    op = 6'b000101; zero = 1'b0;
    adv(); #1;
`ifdef MC_CTRL_BNE_EN
    chk("bne_decode_flag", illegal, 1'b0);
    adv(); #1;
    chk("bne_branch_state", state, 4'd8);
    chk("bne_pcen", pc_en, 1'b1);
    chk("bne_aluop", alu_op, 3'b001);
    adv(); #1;
`else
    chk("bne_decode_flag", illegal, 1'b1);
    adv(); #1;
`endif
    chk("bne_back_fetch", state, 4'd0);

    // Fetch stall: stay in FETCH with the read held, no IR/PC enables
    op = 6'b101011; ready = 1'b0; #1;
    chk("stall_irw", ir_write, 1'b0);
    chk("stall_pcen", pc_en, 1'b0);
    adv(); #1;
    chk("stall_state", state, 4'd0);
    chk("stall_memrd", mem_read, 1'b1);
    ready = 1'b1;

    // sw, then reset while MEMWR is still waiting
    adv(); #1 chk("sw_decode_state", state, 4'd1);
    adv(); #1 chk("sw_memadr_state", state, 4'd2);
    ready = 1'b0;
    adv(); #1;
    chk("sw_memwr_state", state, 4'd5);
    chk("sw_memwr_wr", mem_write, 1'b1);
    chk("sw_memwr_iord", iord, 1'b1);
    chk("sw_memwr_nord", mem_read, 1'b0);
    adv(); #1 chk("sw_memwr_hold", state, 4'd5);
    rst = 1'b1;
    adv(); #1;
    chk("swrst_state", state, 4'd0);
    chk("swrst_memw", mem_write, 1'b0);
    chk("swrst_all_zero", all_out(), 32'd0);
    rst = 1'b0; ready = 1'b1; #1;
    chk("swrel_state", state, 4'd0);
    chk("swrel_memrd", mem_read, 1'b1);
    chk("swrel_irw", ir_write, 1'b1);
    adv(); #1 chk("swrel_decode", state, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multi-cycle MIPS main control unit. It is the producer side of the 3-bit ALUOp interface that the ALU controller consumes.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath mux selects, register-file and memory enables, and the PC enable.
- Sits between the instruction register's opcode field, the memory port handshake and the ALU controller.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, ALUOp width (fixed encoding below).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- instr_op_i  in  6  opcode field of IR (instr[31:26]).
- alu_zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- ALUOp_o  out  3  to ALU controller.
- pc_en_o  out  1  PC register write enable.
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut (branch target).
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  IR load enable.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  1  1 = rd, 0 = rt.
- mem_to_reg_o  out  1  1 = MDR, 0 = ALUOut.
- alu_src_a_o  out  1  0 = PC, 1 = A.
- alu_src_b_o  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- illegal_o  out  1  one-cycle pulse on an unknown opcode.
- state_o  out  4  current state, for debug.

Behaviour:
- ALUOp encoding: 000 lw/sw, 001 beq, 010 R-type, 011 addi, 100 sltiu, 101 lui, 110 ori, 111 andi.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, sltiu 001011, lui 001111, ori 001101, andi 001100.
- State register is 4 bits. States are FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IMMEX=9, IMMWB=10. Encodings 11–15 are unreachable and fall back to FETCH.
- Reset (rst_i=1 at a clock edge):
  - State goes to FETCH and op_q clears to 0.
  - While rst_i is high, all outputs are forced to 0, including ALUOp_o=000 and state_o=0.
  - Reset asserted mid-operation aborts the instruction; no enable is asserted in the cycle after reset.
- op_q register: captures instr_op_i in DECODE. IMMEX uses op_q for its ALUOp.
- Outputs are Moore, decoded from state. Exception: ir_write_o and pc_en_o in FETCH are qualified by mem_ready_i. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, src_a=0, src_b=01, ALUOp=000, pc_src=00, ir_write=pc_en=mem_ready_i.
  - Holds until mem_ready_i, then goes to DECODE.
- DECODE: src_a=0, src_b=11, ALUOp=000. Next state by opcode:
  - lw/sw → MEMADR.
  - R → EXEC.
  - beq → BRANCH.
  - addi/sltiu/lui/ori/andi → IMMEX.
  - Any other opcode → FETCH, with illegal_o=1 in this cycle.
- MEMADR: src_a=1, src_b=10, ALUOp=000. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready_i, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready_i, then goes to FETCH.
- EXEC: src_a=1, src_b=00, ALUOp=010. Next is RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BRANCH: src_a=1, src_b=00, ALUOp=001, pc_src=01, pc_en=alu_zero_i. Next is FETCH.
- IMMEX: src_a=1, src_b=10, ALUOp=011/100/101/110/111 for addi/sltiu/lui/ori/andi. Next is IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- Memory handshake: a request stays asserted and all other outputs stay stable until mem_ready_i. mem_ready_i outside FETCH/MEMRD/MEMWR is ignored.
- mem_read_o and mem_write_o are never both 1.
- Latency with mem_ready_i tied to 1: R/imm/lw/sw/beq take 4/4/5/4/3 cycles. Each wait cycle adds one.

Optional Feature:
- Macro MC_CTRL_BNE_EN.
- When defined: opcode 000101 (bne) is decoded in DECODE and routed to BRANCH. In BRANCH for bne, ALUOp=001 and pc_en=~alu_zero_i.
- When undefined: 000101 is illegal (illegal_o pulse, return to FETCH).

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, …);
  - ALUOp constants (ALUOP_MEM, ALUOP_BEQ, ALUOP_RTYPE, …), which the ALU controller also uses;
  - state encodings (ST_FETCH … ST_IMMWB);
  - src_b and pc_src select constants.
- One natural sub-module: mc_ctrl_outdec, a combinational decode of {state, op_q, mem_ready_i, alu_zero_i} to the control word. The FSM next-state logic and op_q stay in mc_main_ctrl.

Test Plan:
- Reset and R-type: rst_i=1 for 2 cycles, then op=000000, mem_ready_i=1.
  - Outputs are all 0 during reset.
  - state_o then runs 0,1,6,7,0.
  - ALUOp_o=010 in EXEC; reg_write_o=reg_dst_o=1 in RWB.
- lw with waits: op=100011, mem_ready_i low for 2 cycles in MEMRD.
  - state_o runs 0,1,2,3,3,3,4,0.
  - iord_o=1 and mem_read_o=1 throughout MEMRD.
  - mem_to_reg_o=1 and reg_write_o=1 in MEMWB.
- beq: op=000100.
  - alu_zero_i=1 → pc_en_o=1, pc_src_o=01, ALUOp_o=001 in BRANCH.
  - Rerun with alu_zero_i=0 → pc_en_o=0.
- Immediates: ori (001101), andi, sltiu, lui, addi each give ALUOp_o=110/111/100/101/011 in IMMEX, then reg_write_o=1 and reg_dst_o=0 in IMMWB.
- Illegal opcode: op=111111 → illegal_o=1 for exactly the DECODE cycle, next state FETCH, no reg_write_o/mem_write_o. With MC_CTRL_BNE_EN defined, op=000101 with alu_zero_i=0 gives pc_en_o=1.
- Reset mid-store: assert rst_i during MEMWR with mem_ready_i=0.
  - Next cycle state_o=0 and mem_write_o=0.
  - After release, a normal FETCH follows.
